// File: rtl/ahb_bfm_pkg.sv
// Shared AHB-Lite constants, sequencer state encoding and packed-bus index helpers
// for the AHB slave BFM arbiter and related multi-master BFM blocks.
package ahb_bfm_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DATA    = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } ahb_state_e;

  // LSB of element idx in a packed bus of width-bit elements.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

  // Index step positions above last, wrapped into 0..n-1.
  function automatic int rr_next(input int last, input int step, input int n);
    return (last + step) % n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches upward from last_i+1 (mod NREQ) for the
// first active request and returns it one-hot and as a binary index.
module rr_arbiter
  import ahb_bfm_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int LW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [LW-1:0]   last_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [LW-1:0]   idx_o,
  output logic            valid_o
);

  logic [LW-1:0] cand_idx;

  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    cand_idx = '0;
    if (en_i) begin
      for (int i = 1; i <= NREQ; i++) begin
        cand_idx = LW'(rr_next(int'(last_i), i, NREQ));
        if (!valid_o && req_i[cand_idx]) begin
          valid_o         = 1'b1;
          idx_o           = cand_idx;
          gnt_o[cand_idx] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ahb_bfm_arbiter.sv
// Round-robin arbiter and single-transfer AHB-Lite sequencer letting NREQ command
// requesters share one AHB slave BFM; all outputs except HREADY are registered.
module ahb_bfm_arbiter
  import ahb_bfm_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int AWIDTH  = 10,
  parameter int TIMEOUT = 255
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic [NREQ-1:0]        REQ,
  input  logic [NREQ-1:0]        REQ_WRITE,
  input  logic [NREQ*AWIDTH-1:0] REQ_ADDR,
  input  logic [NREQ*3-1:0]      REQ_SIZE,
  input  logic [NREQ*32-1:0]     REQ_WDATA,
  output logic [NREQ-1:0]        GNT,
  output logic [NREQ-1:0]        DONE,
  output logic [31:0]            RDATA,
  output logic                   ERR,
  output logic                   HSEL,
  output logic [1:0]             HTRANS,
  output logic                   HWRITE,
  output logic [AWIDTH-1:0]      HADDR,
  output logic [2:0]             HSIZE,
  output logic [31:0]            HWDATA,
  output logic [2:0]             HBURST,
  output logic [3:0]             HPROT,
  output logic                   HMASTLOCK,
  output logic                   HREADY,
  input  logic [31:0]            HRDATA,
  input  logic                   HREADYOUT,
  input  logic                   HRESP,
  output ahb_state_e             dbg_state_o
);

  localparam int          LW        = $clog2(NREQ);
  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  ahb_state_e state_q, state_d;

  logic [NREQ-1:0]   gnt_q, gnt_d, done_q, done_d;
  logic [31:0]       rdata_q, rdata_d, hwdata_q, hwdata_d;
  logic              err_q, err_d, hsel_q, hsel_d, hwrite_q, hwrite_d;
  logic [1:0]        htrans_q, htrans_d;
  logic [AWIDTH-1:0] haddr_q, haddr_d;
  logic [2:0]        hsize_q, hsize_d;
  logic [LW-1:0]     last_q, last_d;
  logic [15:0]       cnt_q, cnt_d, cnt_inc;
  logic              err_flag_q, err_flag_d, hung_q, hung_d;

  logic              arb_en, arb_valid;
  logic [NREQ-1:0]   arb_gnt;
  logic [LW-1:0]     arb_idx;
  logic              timeout_hit, data_err;

  // After a timeout abort the slave is left alone until it shows HREADYOUT=1 in IDLE.
  assign arb_en = (state_q == ST_IDLE) && (!hung_q || HREADYOUT);

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req_i   (REQ),
    .last_i  (last_q),
    .en_i    (arb_en),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  assign cnt_inc     = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  assign timeout_hit = (state_q == ST_DATA) && !HREADYOUT && (cnt_inc >= TIMEOUT_C);
  assign data_err    = err_flag_q | HRESP;

  always_ff @(posedge HCLK) begin
    if (HRESET) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (arb_valid) state_d = ST_ADDR;
      ST_ADDR: state_d = ST_DATA;
      ST_DATA: if (HREADYOUT || timeout_hit) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt_d      = gnt_q;
    done_d     = '0;
    rdata_d    = rdata_q;
    err_d      = err_q;
    hsel_d     = hsel_q;
    htrans_d   = htrans_q;
    hwrite_d   = hwrite_q;
    haddr_d    = haddr_q;
    hsize_d    = hsize_q;
    hwdata_d   = hwdata_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    err_flag_d = err_flag_q;
    hung_d     = hung_q;
    case (state_q)
      ST_IDLE: begin
        if (HREADYOUT) hung_d = 1'b0;
        if (arb_valid) begin
          gnt_d    = arb_gnt;
          last_d   = arb_idx;
          hsel_d   = 1'b1;
          htrans_d = HTRANS_NONSEQ;
          hwrite_d = REQ_WRITE[arb_idx];
          haddr_d  = REQ_ADDR[slice_lo(int'(arb_idx), AWIDTH) +: AWIDTH];
          hsize_d  = REQ_SIZE[slice_lo(int'(arb_idx), 3) +: 3];
          hwdata_d = REQ_WDATA[slice_lo(int'(arb_idx), 32) +: 32];
        end
      end
      ST_ADDR: begin
        hsel_d     = 1'b0;
        htrans_d   = HTRANS_IDLE;
        cnt_d      = '0;
        err_flag_d = 1'b0;
      end
      ST_DATA: begin
        if (!HREADYOUT) cnt_d = cnt_inc;
        if (timeout_hit) begin
          done_d = gnt_q;
          err_d  = 1'b1;
          hung_d = 1'b1;
        end else if (HREADYOUT) begin
          done_d = gnt_q;
          err_d  = data_err;
          if (!hwrite_q && !data_err) rdata_d = HRDATA;
        end else if (HRESP) begin
          err_flag_d = 1'b1;
        end
      end
      ST_RESP: gnt_d = '0;
      default: ;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      gnt_q      <= '0;
      done_q     <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      hsel_q     <= 1'b0;
      htrans_q   <= HTRANS_IDLE;
      hwrite_q   <= 1'b0;
      haddr_q    <= '0;
      hsize_q    <= '0;
      hwdata_q   <= '0;
      last_q     <= LW'(NREQ - 1);
      cnt_q      <= '0;
      err_flag_q <= 1'b0;
      hung_q     <= 1'b0;
    end else begin
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      hsel_q     <= hsel_d;
      htrans_q   <= htrans_d;
      hwrite_q   <= hwrite_d;
      haddr_q    <= haddr_d;
      hsize_q    <= hsize_d;
      hwdata_q   <= hwdata_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      err_flag_q <= err_flag_d;
      hung_q     <= hung_d;
    end
  end

  assign GNT         = gnt_q;
  assign DONE        = done_q;
  assign RDATA       = rdata_q;
  assign ERR         = err_q;
  assign HSEL        = hsel_q;
  assign HTRANS      = htrans_q;
  assign HWRITE      = hwrite_q;
  assign HADDR       = haddr_q;
  assign HSIZE       = hsize_q;
  assign HWDATA      = hwdata_q;
  assign HBURST      = HBURST_SINGLE;
  assign HPROT       = HPROT_DATA;
  assign HMASTLOCK   = 1'b0;
  assign HREADY      = HREADYOUT;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ahb_bfm_arbiter.sv
// Bench for ahb_bfm_arbiter: table of single transfers against a reactive slave model,
// plus hand sequences for reset mid-transfer, round-robin order and timeout abort.
module tb_ahb_bfm_arbiter;

  logic         HCLK, HRESET;
  logic [3:0]   req, req_write;
  logic [39:0]  req_addr;
  logic [11:0]  req_size;
  logic [127:0] req_wdata;
  logic [3:0]   GNT, DONE;
  logic [31:0]  RDATA, HWDATA, HRDATA;
  logic         ERR, HSEL, HWRITE, HMASTLOCK, HREADY, HREADYOUT, HRESP;
  logic [1:0]   HTRANS, dbg_state;
  logic [9:0]   HADDR;
  logic [2:0]   HSIZE, HBURST;
  logic [3:0]   HPROT;

  ahb_bfm_arbiter #(.NREQ(4), .AWIDTH(10), .TIMEOUT(8)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .REQ(req), .REQ_WRITE(req_write), .REQ_ADDR(req_addr), .REQ_SIZE(req_size),
    .REQ_WDATA(req_wdata),
    .GNT(GNT), .DONE(DONE), .RDATA(RDATA), .ERR(ERR),
    .HSEL(HSEL), .HTRANS(HTRANS), .HWRITE(HWRITE), .HADDR(HADDR), .HSIZE(HSIZE),
    .HWDATA(HWDATA), .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK),
    .HREADY(HREADY), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // scoreboard counters
  int checks = 0;
  int errors = 0;
  int nonseq_cnt = 0;
  int done_cnt = 0;
  int onehot_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // slave model configuration
  int   slv_waits = 0;
  logic slv_err = 1'b0;
  logic slv_hang = 1'b0;

  logic [31:0] mem [256];

  initial begin
    logic       pend, in_data, d_wr, d_err, d_hang, p_wr;
    logic [9:0] p_addr, d_addr;
    int         cyc, d_waits;
    for (int i = 0; i < 256; i++) mem[i] = 32'hA5A5_0000 | 32'(i);
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    HRDATA    = 32'h0;
    pend = 1'b0; in_data = 1'b0; d_wr = 1'b0; d_err = 1'b0; d_hang = 1'b0; p_wr = 1'b0;
    p_addr = '0; d_addr = '0; cyc = 0; d_waits = 0;
    forever begin
      @(negedge HCLK);
      if (pend) begin
        in_data = 1'b1; cyc = 0; pend = 1'b0;
        d_addr = p_addr; d_wr = p_wr;
        d_waits = slv_waits; d_err = slv_err; d_hang = slv_hang;
      end
      HRESP = 1'b0; HREADYOUT = 1'b1; HRDATA = 32'hBAD0_BAD0;
      if (in_data) begin
        if (d_hang) begin
          if (slv_hang) HREADYOUT = 1'b0;
          else in_data = 1'b0;
        end else if (d_err) begin
          HRESP = 1'b1;
          HREADYOUT = (cyc != 0);
          if (cyc != 0) in_data = 1'b0;
        end else if (cyc < d_waits) begin
          HREADYOUT = 1'b0;
        end else begin
          if (d_wr) mem[d_addr[9:2]] = HWDATA;
          else HRDATA = mem[d_addr[9:2]];
          in_data = 1'b0;
        end
        cyc++;
      end
      if (HSEL && HTRANS == 2'b10 && HREADYOUT) begin
        pend = 1'b1; p_addr = HADDR; p_wr = HWRITE;
      end
    end
  end

  // monitor
  initial begin
    forever begin
      @(negedge HCLK);
      if (HTRANS == 2'b10) nonseq_cnt++;
      if (DONE != 4'b0) done_cnt++;
      if ((GNT != 4'b0 && !$onehot(GNT)) || (DONE != 4'b0 && !$onehot(DONE))) onehot_err++;
    end
  end

  // driver tasks
  task automatic set_fields(input int id, input logic wr, input logic [9:0] a,
                            input logic [31:0] wd);
    req_write[id]        = wr;
    req_addr[id*10 +: 10] = a;
    req_size[id*3 +: 3]   = 3'b010;
    req_wdata[id*32 +: 32] = wd;
  endtask

  typedef struct {
    int          id;
    logic        wr;
    logic [9:0]  addr;
    logic [31:0] wdata;
    int          waits;
    logic        serr;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  task automatic run_vec(input vec_t v, input int k);
    int         lat, ns0;
    logic       seen;
    logic [3:0] exp_oh;
    exp_oh = 4'b0001 << v.id;
    ns0 = nonseq_cnt;
    set_fields(v.id, v.wr, v.addr, v.wdata);
    slv_waits = v.waits; slv_err = v.serr; slv_hang = 1'b0;
    req[v.id] = 1'b1;
    lat = 0; seen = 1'b0;
    while (lat < 40 && !seen) begin
      @(negedge HCLK);
      lat++;
      if (lat == 1) begin
        check($sformatf("v%0d_gnt", k), 32'(GNT), 32'(exp_oh));
        req[v.id] = 1'b0;
      end
      if (DONE != 4'b0) seen = 1'b1;
    end
    check($sformatf("v%0d_done_seen", k), 32'(seen), 32'd1);
    if (seen) begin
      check($sformatf("v%0d_latency", k), 32'(lat), 32'(v.exp_lat));
      check($sformatf("v%0d_done", k), 32'(DONE), 32'(exp_oh));
      check($sformatf("v%0d_gnt_held", k), 32'(GNT), 32'(exp_oh));
      check($sformatf("v%0d_rdata", k), RDATA, v.exp_rdata);
      check($sformatf("v%0d_err", k), 32'(ERR), 32'(v.exp_err));
      check($sformatf("v%0d_nonseq", k), 32'(nonseq_cnt - ns0), 32'd1);
    end
    @(negedge HCLK);
    check($sformatf("v%0d_done_pulse", k), 32'(DONE), 32'd0);
    check($sformatf("v%0d_gnt_clear", k), 32'(GNT), 32'd0);
  endtask

  vec_t vecs[9];

  initial begin
    int         lat, k, ns1, d0;
    logic [3:0] ord [5];
    int         tm [5];
    logic [31:0] rd [5];
    logic [3:0]  exp_ord [5];
    logic [31:0] exp_rd [5];
    logic        seen;

    //            id wr    addr     wdata         waits err   exp_rdata      exp_err lat
    vecs[0] = '{0, 1'b1, 10'h040, 32'hDEADBEEF, 0, 1'b0, 32'h0000_0000, 1'b0, 3};
    vecs[1] = '{0, 1'b0, 10'h040, 32'h0,        0, 1'b0, 32'hDEADBEEF, 1'b0, 3};
    vecs[2] = '{1, 1'b1, 10'h100, 32'h12345678, 2, 1'b0, 32'hDEADBEEF, 1'b0, 5};
    vecs[3] = '{3, 1'b0, 10'h100, 32'h0,        3, 1'b0, 32'h12345678, 1'b0, 6};
    vecs[4] = '{2, 1'b1, 10'h080, 32'hCAFEF00D, 0, 1'b1, 32'h12345678, 1'b1, 4};
    vecs[5] = '{1, 1'b0, 10'h080, 32'h0,        0, 1'b0, 32'hA5A50020, 1'b0, 3};
    vecs[6] = '{2, 1'b0, 10'h044, 32'h0,        0, 1'b1, 32'hA5A50020, 1'b1, 4};
    vecs[7] = '{3, 1'b1, 10'h3FC, 32'h0F0F0F0F, 1, 1'b0, 32'hA5A50020, 1'b0, 4};
    vecs[8] = '{0, 1'b0, 10'h3FC, 32'h0,        0, 1'b0, 32'h0F0F0F0F, 1'b0, 3};

    HRESET = 1'b1;
    req = '0; req_write = '0; req_addr = '0; req_size = '0; req_wdata = '0;
    repeat (3) @(negedge HCLK);
    check("rst_gnt", 32'(GNT), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_rdata", RDATA, 32'd0);
    check("rst_err", 32'(ERR), 32'd0);
    check("rst_hsel", 32'(HSEL), 32'd0);
    check("rst_htrans", 32'(HTRANS), 32'd0);
    check("rst_haddr", 32'(HADDR), 32'd0);
    check("rst_hwdata", HWDATA, 32'd0);
    check("hburst", 32'(HBURST), 32'd0);
    check("hprot", 32'(HPROT), 32'd3);
    check("hmastlock", 32'(HMASTLOCK), 32'd0);
    check("hready_idle", 32'(HREADY), 32'd1);
    HRESET = 1'b0;
    @(negedge HCLK);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // reset while requester 2 sits in the data phase
    set_fields(2, 1'b0, 10'h040, 32'h0);
    slv_waits = 5; slv_err = 1'b0;
    req[2] = 1'b1;
    @(negedge HCLK);
    check("mid_gnt", 32'(GNT), 32'h4);
    @(negedge HCLK);
    HRESET = 1'b1;
    @(negedge HCLK);
    HRESET = 1'b0;
    req = '0;
    check("mid_rst_gnt", 32'(GNT), 32'd0);
    check("mid_rst_done", 32'(DONE), 32'd0);
    check("mid_rst_rdata", RDATA, 32'd0);
    check("mid_rst_hsel", 32'(HSEL), 32'd0);
    check("mid_rst_htrans", 32'(HTRANS), 32'd0);
    check("mid_rst_haddr", 32'(HADDR), 32'd0);
    check("mid_rst_hsize", 32'(HSIZE), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'(ahb_bfm_pkg::ST_IDLE));
    d0 = done_cnt;
    repeat (10) @(negedge HCLK);
    check("mid_rst_no_done", 32'(done_cnt), 32'(d0));

    // all four requesters held high: order 0,1,2,3,0 with 4-cycle spacing
    set_fields(0, 1'b0, 10'h040, 32'h0);
    set_fields(1, 1'b0, 10'h100, 32'h0);
    set_fields(2, 1'b0, 10'h080, 32'h0);
    set_fields(3, 1'b0, 10'h3FC, 32'h0);
    exp_ord = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    exp_rd  = '{32'hDEADBEEF, 32'h12345678, 32'hA5A50020, 32'h0F0F0F0F, 32'hDEADBEEF};
    slv_waits = 0;
    req = 4'hF;
    k = 0; lat = 0;
    while (k < 5 && lat < 60) begin
      @(negedge HCLK);
      lat++;
      if (DONE != 4'b0) begin
        ord[k] = DONE; tm[k] = lat; rd[k] = RDATA; k++;
        if (k == 5) req = '0;
      end
    end
    req = '0;
    check("rr_count", 32'(k), 32'd5);
    if (k == 5) begin
      check("rr_first_lat", 32'(tm[0]), 32'd3);
      for (int i = 0; i < 5; i++) begin
        check($sformatf("rr_order%0d", i), 32'(ord[i]), 32'(exp_ord[i]));
        check($sformatf("rr_rdata%0d", i), rd[i], exp_rd[i]);
        if (i > 0) check($sformatf("rr_spacing%0d", i), 32'(tm[i] - tm[i-1]), 32'd4);
      end
    end
    repeat (2) @(negedge HCLK);

    // slave holds HREADYOUT low: abort after 8 data cycles, then stay off the bus
    set_fields(1, 1'b0, 10'h100, 32'h0);
    slv_hang = 1'b1;
    req[1] = 1'b1;
    lat = 0; seen = 1'b0;
    while (lat < 40 && !seen) begin
      @(negedge HCLK);
      lat++;
      if (lat == 1) req[1] = 1'b0;
      if (DONE != 4'b0) seen = 1'b1;
    end
    check("to_done_seen", 32'(seen), 32'd1);
    check("to_latency", 32'(lat), 32'd10);
    check("to_done", 32'(DONE), 32'h2);
    check("to_err", 32'(ERR), 32'd1);
    check("to_rdata", RDATA, 32'hDEADBEEF);
    req[2] = 1'b1;
    ns1 = nonseq_cnt;
    repeat (6) @(negedge HCLK);
    check("to_hold_gnt", 32'(GNT), 32'd0);
    check("to_hold_nonseq", 32'(nonseq_cnt - ns1), 32'd0);
    check("to_hold_hready", 32'(HREADY), 32'd0);
    @(posedge HCLK);
    slv_hang = 1'b0;
    lat = 0; seen = 1'b0;
    while (lat < 40 && !seen) begin
      @(negedge HCLK);
      lat++;
      if (GNT[2]) req[2] = 1'b0;
      if (DONE != 4'b0) seen = 1'b1;
    end
    req = '0;
    check("rec_latency", 32'(lat), 32'd4);
    check("rec_done", 32'(DONE), 32'h4);
    check("rec_err", 32'(ERR), 32'd0);
    check("rec_rdata", RDATA, 32'hA5A50020);
    repeat (2) @(negedge HCLK);

    check("onehot_violations", 32'(onehot_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_bfm_arbiter.md
Name: ahb_bfm_arbiter

Overview:
Round-robin arbiter and AHB-Lite transfer sequencer that lets NREQ simple command requesters share one AHB slave BFM instance. It owns the single master-side AHB port into the slave. It issues one single (non-burst) NONSEQ transfer at a time, handles wait states and two-cycle error responses, and returns read data and status to the granted requester. It sits between testbench command sources (or an internal host model) and the AHB slave BFM.

Parameters:
NREQ, 4, number of requesters (2..8)
AWIDTH, 10, address width; matches the slave BFM AWIDTH
TIMEOUT, 255, max consecutive HREADYOUT-low cycles in the data phase before abort (1..65535)

Ports:
HCLK  in  1  clock
HRESET  in  1  synchronous reset, active-high
REQ  in  NREQ  per-requester transfer request
REQ_WRITE  in  NREQ  1=write, 0=read
REQ_ADDR  in  NREQ*AWIDTH  packed addresses; requester i uses slice [i*AWIDTH +: AWIDTH]
REQ_SIZE  in  NREQ*3  packed HSIZE values
REQ_WDATA  in  NREQ*32  packed write data
GNT  out  NREQ  one-hot; high for the whole owned transfer
DONE  out  NREQ  one-cycle one-hot completion pulse
RDATA  out  32  read data; valid with DONE
ERR  out  1  error status; valid with DONE (HRESP error or timeout)
HSEL  out  1  slave select
HTRANS  out  2  00 IDLE, 10 NONSEQ only
HWRITE, HADDR[AWIDTH], HSIZE[3], HWDATA[32]  out  -  AHB master signals
HBURST  out  3  constant 000
HPROT  out  4  constant 0011
HMASTLOCK  out  1  constant 0
HREADY  out  1  combinational copy of HREADYOUT; drives the slave HREADYIN
HRDATA  in  32  slave read data
HREADYOUT  in  1  slave ready
HRESP  in  1  slave error response

Behaviour:
- Reset values: all outputs registered. GNT=0, DONE=0, RDATA=0, ERR=0, HSEL=0, HTRANS=00, HWRITE=0, HADDR=0, HSIZE=0, HWDATA=0. The RR pointer selects requester 0 first. FSM=IDLE.
- States: IDLE, ADDR, DATA, RESP.
- IDLE: if any REQ bit is high, pick the winner by round-robin, searching upward from last_winner+1 modulo NREQ. Register the winner's fields, set GNT[w]=1, update last_winner=w, and go to ADDR.
- ADDR (exactly 1 cycle): HSEL=1, HTRANS=10, HADDR/HWRITE/HSIZE from the latched fields. Go to DATA.
- DATA: HTRANS=00, HSEL=0. HWDATA holds the latched wdata for the whole state. Count cycles with HREADYOUT=0.
  - HREADYOUT=1 and HRESP=0: capture HRDATA (reads only; RDATA unchanged on writes), ERR=0, go to RESP.
  - HRESP=1 and HREADYOUT=0 (first error cycle): set the error flag and stay. On the following HREADYOUT=1 cycle, go to RESP with ERR=1.
  - Counter reaches TIMEOUT: abort, ERR=1, go to RESP. The slave is not re-accessed until HREADYOUT=1 has been seen once in IDLE.
- RESP (1 cycle): DONE[w]=1, GNT cleared at the end of the cycle, go to IDLE.
- Best-case latency: REQ sampled in cycle n; ADDR phase in n+1; DATA in n+2 with zero wait states; DONE in n+3. Each wait state adds one cycle. Minimum 4 cycles per transfer; one dead IDLE cycle between back-to-back transfers.
- Requester contract:
  - Fields must be stable from REQ high until DONE. The arbiter latches them at grant.
  - Dropping REQ before GNT withdraws the request.
  - Dropping REQ after GNT has no effect; the transfer completes.
- Simultaneous requests: one winner per IDLE cycle. No requester is starved: worst-case wait is (NREQ-1) transfers.
- Reset mid-transfer: return to IDLE immediately and drive all outputs to reset values. No DONE is issued.
- Timeout counter: 16 bits, saturating. Cleared on entry to DATA.

Decomposition:
- Package ahb_bfm_pkg holds:
  - HTRANS_IDLE/NONSEQ, HBURST_SINGLE, HPROT_DATA constants.
  - The FSM state enum.
  - Packed-slice index helpers.
- Sub-module rr_arbiter (NREQ): inputs are the request vector, last_winner and an enable. Outputs are the one-hot grant and the binary index. It is purely combinational and is reused by later multi-master BFM work.

Test Plan:
- Single write then read, zero wait states: req0 writes 0xDEADBEEF to 0x040, then reads 0x040 -> HTRANS=10 for exactly 1 cycle each; DONE[0] at n+3; RDATA=0xDEADBEEF; ERR=0.
- All 4 REQ high together, held high -> grant order 0,1,2,3,0; 4-cycle spacing between DONE pulses; GNT always one-hot.
- Slave inserts 3 wait states on a read -> DONE at n+6; RDATA captured only on the HREADYOUT=1 cycle.
- Two-cycle HRESP error on a write -> ERR=1 with DONE; next requester is serviced normally.
- HREADYOUT held low with TIMEOUT=8 -> DONE with ERR=1 after 8 DATA cycles; no new NONSEQ until HREADYOUT returns high.
- HRESET asserted in the DATA state -> next cycle all outputs at reset values, no DONE; the next transfer after release goes to requester 0.
